readout_scheduler: RTL and testbench
====================================

// Module: readout_scheduler
// PURPOSE
//  Burst-based round-robin scheduler between the per-channel 32-bit front-end RX FIFOs (+TDC slot) and the
//  shared 32->8 TCP data FIFO. Grants one source at a time for up to BURST words, honours downstream
//  back-pressure, supports a runtime channel enable mask and counts forwarded words. Lives in BUS_CLK domain.
// PARAMETERS
//  NSRC   5   number of requesting sources (index 0 = TDC, 1..4 = FE channels)
//  BURST  16  max words popped per grant (>=1)
//  DW     32  data word width
// PORTS
//  BUS_CLK      in   1        single clock; all logic rising-edge
//  RSTn         in   1        synchronous, active-low reset
//  ENABLE       in   NSRC     per-source enable mask; disabled sources never granted
//  WRITE_REQ    in   NSRC     source FIFO not-empty (first-word-fall-through)
//  DATA_IN      in   NSRC*DW  source data, source k at [k*DW +: DW]
//  READ_GRANT   out  NSRC     pop strobe to source FIFO (combinational from state)
//  READY_OUT    in   1        downstream can accept >=2 more words
//  WRITE_OUT    out  1        registered write strobe to downstream
//  DATA_OUT     out  DW       registered data, valid when WRITE_OUT=1
//  GRANT_ID     out  clog2(NSRC)  currently/last granted source
//  BUSY         out  1        1 while in BURST state
//  CNT_CLR      in   1        synchronous clear of WORD_CNT
//  WORD_CNT     out  32       words forwarded since reset/clear, wraps at 2^32
// BEHAVIOUR
//  Reset (RSTn=0 at edge): state=IDLE, READ_GRANT=0, WRITE_OUT=0, DATA_OUT=0, GRANT_ID=NSRC-1, BUSY=0,
//   WORD_CNT=0, burst count=0. Reset mid-burst aborts; in-flight word is dropped (not written).
//  States: IDLE, BURST.
//  IDLE: req = WRITE_REQ & ENABLE. If req!=0: pick first set bit searching GRANT_ID+1, +2, ... mod NSRC
//   (rotating priority; last-served source is lowest priority); load GRANT_ID, cnt=0, -> BURST.
//   Else stay. READ_GRANT=0 in IDLE (one-cycle arbitration bubble between bursts).
//  BURST: READ_GRANT[GRANT_ID] = WRITE_REQ[GRANT_ID] & ENABLE[GRANT_ID] & READY_OUT; all other bits 0.
//   Each pop: cnt++. -> IDLE when pop with cnt==BURST-1, or WRITE_REQ[GRANT_ID]=0, or ENABLE[GRANT_ID]=0.
//   READY_OUT=0 alone does not end a burst (stall, hold grant).
//  Datapath: WRITE_OUT <= |READ_GRANT; DATA_OUT <= DATA_IN[GRANT_ID] when pop, else hold. Latency pop->write 1 clk.
//  At most one READ_GRANT bit high per cycle; never asserted when corresponding WRITE_REQ=0.
//  WORD_CNT: +1 on each WRITE_OUT; CNT_CLR takes priority over increment in same cycle; wraps 0xFFFFFFFF->0.
//  ENABLE change: effective next cycle; a burst on a newly disabled source ends without further pops.
//  Single requester: re-granted after each 1-cycle bubble (throughput BURST/(BURST+1)).
//  BURST=1: each grant pops exactly one word then returns to IDLE.
// STRUCTURE
//  Shared package/header readout_defs: DW, NSRC, source index constants (SRC_TDC=0, SRC_FE0=1..).
//  One sub-module: rr_pick (combinational rotating priority encoder: req, last -> valid, idx).
//  Top holds FSM, burst counter, output registers, WORD_CNT.
// TESTING
//  1 Reset: RSTn=0 2 clks with all WRITE_REQ=1 -> READ_GRANT=0, WRITE_OUT=0, WORD_CNT=0, GRANT_ID=4.
//  2 Fairness: BURST=4, sources 1,3 each hold 8 words, READY=1 -> grant order 1,3,1,3, 4 pops each, 1-clk gaps, WORD_CNT=16.
//  3 Back-pressure: src 2 with 10 words, drop READY_OUT for 5 clks mid-burst -> no pops, grant held,
//    all 10 words out in order, no duplicates/loss.
//  4 Early end: src 0 has 2 words, BURST=16 -> 2 pops, IDLE after 2nd; next req (src 1) granted after 1 bubble.
//  5 Mask: ENABLE=5'b11101, src 1 requesting continuously -> never granted; clear bit mid-burst of src 2 ->
//    pops stop next cycle.
//  6 Counter: preload via 2^32-1 writes (force) then one write -> WORD_CNT=0; CNT_CLR with write same clk -> 0.

Source files
------------

// File: rtl/readout_scheduler_pkg.sv
// Shared constants and types for the readout scheduler: default geometry,
// source index map and FSM state encoding.
package readout_scheduler_pkg;

    localparam int unsigned NSRC_DEF  = 5;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned BURST_DEF = 16;
    localparam int unsigned CNT_W     = 32;

    localparam int unsigned SRC_TDC = 0;
    localparam int unsigned SRC_FE0 = 1;
    localparam int unsigned SRC_FE1 = 2;
    localparam int unsigned SRC_FE2 = 3;
    localparam int unsigned SRC_FE3 = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } sched_state_e;

    // Width of a source index; never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/readout_scheduler_if.sv
// Source-side / downstream-side bundle of the readout scheduler.
interface readout_scheduler_if
    import readout_scheduler_pkg::*;
#(
    parameter int unsigned NSRC = NSRC_DEF,
    parameter int unsigned DW   = DW_DEF
);
    localparam int unsigned IW = idx_w(NSRC);

    logic [NSRC-1:0]    ENABLE;
    logic [NSRC-1:0]    WRITE_REQ;
    logic [NSRC*DW-1:0] DATA_IN;
    logic [NSRC-1:0]    READ_GRANT;
    logic               READY_OUT;
    logic               WRITE_OUT;
    logic [DW-1:0]      DATA_OUT;
    logic [IW-1:0]      GRANT_ID;
    logic               BUSY;
    logic               CNT_CLR;
    logic [CNT_W-1:0]   WORD_CNT;

    modport master (
        input  ENABLE, WRITE_REQ, DATA_IN, READY_OUT, CNT_CLR,
        output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY, WORD_CNT
    );

    modport slave (
        output ENABLE, WRITE_REQ, DATA_IN, READY_OUT, CNT_CLR,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_ID, BUSY, WORD_CNT
    );

endinterface

// File: rtl/readout_scheduler_rr_pick.sv
// Rotating priority encoder: first requester after the last-served index wins,
// so the last-served source has the lowest priority.
module readout_scheduler_rr_pick #(
    parameter int unsigned NSRC = 5,
    parameter int unsigned IW   = 3
) (
    input  logic [NSRC-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = NSRC; i >= 1; i--) begin
            cand = IW'((32'(last_i) + i) % NSRC);
            if (req_i[cand]) idx_o = cand;
        end
    end

endmodule

// File: rtl/readout_scheduler.sv
// Burst round-robin scheduler from per-source FWFT FIFOs into one shared
// downstream FIFO, with enable mask, back-pressure and a forwarded-word counter.
module readout_scheduler
    import readout_scheduler_pkg::*;
#(
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned BURST = BURST_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input logic                BUS_CLK,
    input logic                RSTn,
    readout_scheduler_if.master bus
);

    localparam int unsigned IW = idx_w(NSRC);
    localparam int unsigned CW = $clog2(BURST + 1);

    sched_state_e     state_q, state_d;
    logic [IW-1:0]    gid_q, gid_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_q;
    logic [DW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic [NSRC-1:0]  req_c;
    logic [NSRC-1:0]  grant_c;
    logic             pick_valid_c;
    logic [IW-1:0]    pick_idx_c;
    logic             src_live_c;
    logic             pop_c;

    assign req_c      = bus.WRITE_REQ & bus.ENABLE;
    assign src_live_c = bus.WRITE_REQ[gid_q] & bus.ENABLE[gid_q];
    assign pop_c      = (state_q == ST_BURST) & src_live_c & bus.READY_OUT;

    readout_scheduler_rr_pick #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_pick (
        .req_i   (req_c),
        .last_i  (gid_q),
        .valid_o (pick_valid_c),
        .idx_o   (pick_idx_c)
    );

    // Next state, grant and burst count; a stall holds the grant without popping.
    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        grant_c = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid_c) begin
                    state_d = ST_BURST;
                    gid_d   = pick_idx_c;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (pop_c) begin
                    grant_c[gid_q] = 1'b1;
                    cnt_d          = cnt_q + CW'(1);
                end
                if (!src_live_c || (pop_c && (cnt_q == CW'(BURST - 1)))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_d = pop_c ? bus.DATA_IN[32'(gid_q) * DW +: DW] : data_q;
    assign wcnt_d = bus.CNT_CLR ? '0 : (wcnt_q + CNT_W'(wr_q));

    always_ff @(posedge BUS_CLK) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            gid_q   <= IW'(NSRC - 1);
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            wr_q    <= |grant_c;
            data_q  <= data_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.READ_GRANT = grant_c;
    assign bus.WRITE_OUT  = wr_q;
    assign bus.DATA_OUT   = data_q;
    assign bus.GRANT_ID   = gid_q;
    assign bus.BUSY       = (state_q == ST_BURST);
    assign bus.WORD_CNT   = wcnt_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler: FWFT source FIFO model, arbitration
// vector table and hand-written burst / back-pressure / mask / counter sequences.
module tb_readout_scheduler;
    import readout_scheduler_pkg::*;

    localparam int unsigned NSRC  = NSRC_DEF;
    localparam int unsigned DW    = DW_DEF;
    localparam int unsigned BURST = 4;
    localparam int          NROWS = 8;

    typedef struct {
        logic [NSRC-1:0] req;
        logic [NSRC-1:0] en;
        int              first;
        int              last;
        int              pops;
    } row_t;

    logic clk;
    logic rstn;

    readout_scheduler_if #(.NSRC(NSRC), .DW(DW)) bus ();

    readout_scheduler #(.NSRC(NSRC), .BURST(BURST), .DW(DW)) dut (
        .BUS_CLK (clk),
        .RSTn    (rstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]   fifo [NSRC][$];
    logic [NSRC-1:0] en;
    logic            ready;
    logic            clr;
    logic            exp_wr;
    logic [DW-1:0]   exp_data;
    logic [31:0]     exp_cnt;
    int              pop_src[$];
    int              pop_cyc[$];
    logic [DW-1:0]   out_q[$];
    int              cyc;
    int              n_cmp;
    int              n_bad;
    row_t            tbl [NROWS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NSRC; k++) begin
            bus.WRITE_REQ[k]         = (fifo[k].size() != 0);
            bus.DATA_IN[k*DW +: DW]  = (fifo[k].size() != 0) ? fifo[k][0] : '0;
        end
        bus.ENABLE    = en;
        bus.READY_OUT = ready;
        bus.CNT_CLR   = clr;
    endtask

    // One clock: drive at negedge, observe grant, pop model FIFO, check outputs next negedge.
    task automatic cycle();
        logic [NSRC-1:0] g;
        logic [NSRC-1:0] allowed;
        int              src;
        drive_inputs();
        #1;
        g       = bus.READ_GRANT;
        allowed = bus.WRITE_REQ & en & {NSRC{ready}};
        chk("grant_legal", 64'(((g & ~allowed) == '0) && ($countones(g) <= 1)), 64'(1));
        src = -1;
        for (int k = 0; k < NSRC; k++) if (g[k]) src = k;
        if (clr) exp_cnt = '0;
        else if (exp_wr) exp_cnt = exp_cnt + 32'd1;
        if (src >= 0 && fifo[src].size() != 0) begin
            exp_data = fifo[src].pop_front();
            pop_src.push_back(src);
            pop_cyc.push_back(cyc);
        end
        exp_wr = (src >= 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("write_out", 64'(bus.WRITE_OUT), 64'(exp_wr));
        if (exp_wr) begin
            chk("data_out", 64'(bus.DATA_OUT), 64'(exp_data));
            out_q.push_back(bus.DATA_OUT);
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < NSRC; k++) if (en[k] && fifo[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int count_src(input int s);
        int c = 0;
        foreach (pop_src[i]) if (pop_src[i] == s) c++;
        return c;
    endfunction

    task automatic run_drain(input int maxc);
        int n = 0;
        while ((pending() || exp_wr || bus.BUSY) && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 64'(n >= maxc), 64'(0));
        repeat (3) cycle();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int k = 0; k < NSRC; k++) fifo[k].delete();
        clr   = 1'b0;
        ready = 1'b1;
        en    = '1;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        exp_wr   = 1'b0;
        exp_data = '0;
        exp_cnt  = '0;
        pop_src.delete();
        pop_cyc.delete();
        out_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;
        int p0;
        int n;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;

        // Starting GRANT_ID is 4; each row's expectation follows from the previous row's last.
        tbl[0] = '{req: 5'b00001, en: 5'b11111, first: 0,  last: 0, pops: 1};
        tbl[1] = '{req: 5'b10110, en: 5'b11111, first: 1,  last: 4, pops: 3};
        tbl[2] = '{req: 5'b11111, en: 5'b11101, first: 0,  last: 4, pops: 4};
        tbl[3] = '{req: 5'b01001, en: 5'b11111, first: 0,  last: 3, pops: 2};
        tbl[4] = '{req: 5'b10001, en: 5'b11111, first: 4,  last: 0, pops: 2};
        tbl[5] = '{req: 5'b00110, en: 5'b00100, first: 2,  last: 2, pops: 1};
        tbl[6] = '{req: 5'b00000, en: 5'b11111, first: -1, last: 2, pops: 0};
        tbl[7] = '{req: 5'b00011, en: 5'b11111, first: 0,  last: 1, pops: 2};

        // Reset with every source requesting.
        rstn  = 1'b0;
        en    = '1;
        ready = 1'b1;
        clr   = 1'b0;
        for (int k = 0; k < NSRC; k++) fifo[k].push_back(DW'(32'h5500_0000 + 32'(k)));
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read_grant", 64'(bus.READ_GRANT), 64'(0));
        chk("rst_write_out",  64'(bus.WRITE_OUT),  64'(0));
        chk("rst_word_cnt",   64'(bus.WORD_CNT),   64'(0));
        chk("rst_grant_id",   64'(bus.GRANT_ID),   64'(4));
        chk("rst_busy",       64'(bus.BUSY),       64'(0));
        chk("rst_data_out",   64'(bus.DATA_OUT),   64'(0));
        do_reset();

        // Arbitration table: one word per requester.
        for (int r = 0; r < NROWS; r++) begin
            pop_src.delete();
            en = tbl[r].en;
            for (int k = 0; k < NSRC; k++)
                if (tbl[r].req[k]) fifo[k].push_back(DW'(32'hA000_0000 + 32'(r) * 256 + 32'(k)));
            run_drain(60);
            first = (pop_src.size() > 0) ? pop_src[0] : -1;
            chk($sformatf("row%0d_first", r), 64'(first), 64'(tbl[r].first));
            chk($sformatf("row%0d_pops", r),  64'(pop_src.size()), 64'(tbl[r].pops));
            chk($sformatf("row%0d_last", r),  64'(bus.GRANT_ID), 64'(tbl[r].last));
            for (int k = 0; k < NSRC; k++) if (!en[k]) fifo[k].delete();
        end
        chk("table_word_cnt", 64'(bus.WORD_CNT), 64'(15));

        // Fairness: two sources with 8 words each, bursts of 4 alternate with 1-clk gaps.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fifo[SRC_FE0].push_back(DW'(32'h1100_0000 + 32'(i)));
            fifo[SRC_FE2].push_back(DW'(32'h3300_0000 + 32'(i)));
        end
        run_drain(100);
        chk("fair_pops", 64'(pop_src.size()), 64'(16));
        if (pop_src.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("fair_src%0d", i), 64'(pop_src[i]), 64'(((i / 4) % 2 == 0) ? SRC_FE0 : SRC_FE2));
                chk($sformatf("fair_cyc%0d", i), 64'(pop_cyc[i] - pop_cyc[0]), 64'(i + i / 4));
            end
        end
        chk("fair_word_cnt", 64'(bus.WORD_CNT), 64'(16));

        // Back-pressure mid-burst on source 2.
        do_reset();
        for (int i = 0; i < 10; i++) fifo[SRC_FE1].push_back(DW'(32'hB000_0000 + 32'(i)));
        n = 0;
        while (pop_src.size() < 2 && n < 10) begin
            cycle();
            n++;
        end
        chk("bp_start", 64'(pop_src.size()), 64'(2));
        ready = 1'b0;
        p0    = pop_src.size();
        repeat (5) cycle();
        chk("bp_no_pop",   64'(pop_src.size()), 64'(p0));
        chk("bp_busy",     64'(bus.BUSY),       64'(1));
        chk("bp_grant_id", 64'(bus.GRANT_ID),   64'(SRC_FE1));
        ready = 1'b1;
        run_drain(60);
        chk("bp_out_count", 64'(out_q.size()), 64'(10));
        if (out_q.size() == 10)
            for (int i = 0; i < 10; i++)
                chk($sformatf("bp_word%0d", i), 64'(out_q[i]), 64'(32'hB000_0000 + 32'(i)));

        // Early end: source 0 runs dry after 2 words, source 1 follows.
        do_reset();
        fifo[SRC_TDC].push_back(DW'(32'hC000_0000));
        fifo[SRC_TDC].push_back(DW'(32'hC000_0001));
        fifo[SRC_FE0].push_back(DW'(32'hC100_0000));
        run_drain(40);
        chk("early_pops", 64'(pop_src.size()), 64'(3));
        if (pop_src.size() == 3) begin
            chk("early_src0", 64'(pop_src[0]), 64'(SRC_TDC));
            chk("early_src1", 64'(pop_src[1]), 64'(SRC_TDC));
            chk("early_src2", 64'(pop_src[2]), 64'(SRC_FE0));
            chk("early_gap",  64'(pop_cyc[2] - pop_cyc[1] <= 3), 64'(1));
        end

        // Mask: source 1 disabled throughout; source 2 disabled mid-burst.
        do_reset();
        en = 5'b11101;
        for (int i = 0; i < 8; i++)  fifo[SRC_FE0].push_back(DW'(32'hD100_0000 + 32'(i)));
        for (int i = 0; i < 10; i++) fifo[SRC_FE1].push_back(DW'(32'hD200_0000 + 32'(i)));
        n = 0;
        while (count_src(SRC_FE1) < 2 && n < 10) begin
            cycle();
            n++;
        end
        chk("mask_start", 64'(count_src(SRC_FE1)), 64'(2));
        en = 5'b11001;
        repeat (10) cycle();
        chk("mask_src2_stopped", 64'(count_src(SRC_FE1)), 64'(2));
        chk("mask_src1_never",   64'(count_src(SRC_FE0)), 64'(0));
        chk("mask_idle",         64'(bus.BUSY), 64'(0));
        en = 5'b11111;
        run_drain(100);
        chk("mask_src1_after", 64'(count_src(SRC_FE0)), 64'(8));
        chk("mask_src2_after", 64'(count_src(SRC_FE1)), 64'(10));

        // Counter wrap and clear priority.
        do_reset();
        force dut.wcnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.wcnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        chk("cnt_preload", 64'(bus.WORD_CNT), 64'(32'hFFFF_FFFF));
        fifo[SRC_TDC].push_back(DW'(32'hE000_0000));
        run_drain(20);
        chk("cnt_wrap", 64'(bus.WORD_CNT), 64'(0));
        for (int i = 0; i < 3; i++) fifo[SRC_FE2].push_back(DW'(32'hE300_0000 + 32'(i)));
        n = 0;
        while (bus.WRITE_OUT !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        chk("cnt_clr_reach", 64'(bus.WRITE_OUT), 64'(1));
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("cnt_clr_prio", 64'(bus.WORD_CNT), 64'(0));
        run_drain(20);
        chk("cnt_after_clr", 64'(bus.WORD_CNT), 64'(2));
        chk("cnt_model",     64'(bus.WORD_CNT), 64'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
